// File: rtl/yutorina_bus_slave_regs.sv
// Bus responder holding a small bank of 32-bit read/write registers.
// Answers each accepted access with a one-cycle registered rdy_ pulse after WAIT_CYCLES wait states.
module yutorina_bus_slave_regs #(
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic              s_as_,
    input  logic              s_rw,
    input  logic [DATA_W-1:0] s_w_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;
    localparam logic        READ  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DEPTH_LOG2-1:0]   idx_nxt;
    logic                    rw_q;
    logic                    rw_nxt;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       wdata_nxt;
    logic                    wr_en;
    logic [DATA_W-1:0]       rd_data_nxt;
    logic                    rdy_nxt;
    logic [DATA_W-1:0]       regs [DEPTH];

    // Upper address bits alias onto the bank; decoding belongs to the address decoder.
    logic unused_addr_hi;
    assign unused_addr_hi = ^s_addr[ADDR_W-1:DEPTH_LOG2];

    // State and transaction latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx_q   <= '0;
            rw_q    <= READ;
            wdata_q <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            idx_q   <= idx_nxt;
            rw_q    <= rw_nxt;
            wdata_q <= wdata_nxt;
        end
    end

    // Next-state, latch updates and registered-output precompute
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx_q;
        rw_nxt     = rw_q;
        wdata_nxt  = wdata_q;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_ && !s_as_) begin
                    idx_nxt    = s_addr[DEPTH_LOG2-1:0];
                    rw_nxt     = s_rw;
                    wdata_nxt  = s_w_data;
                    cnt_nxt    = CNT_W'(WAIT_CYCLES);
                    next_state = (WAIT_CYCLES != 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    next_state = ACK;
                end
            end
            ACK: begin
                next_state = IDLE;
                wr_en      = (rw_q != READ);
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Outputs are set up one edge ahead so rdy_/rd_data come straight from flops.
        rdy_nxt     = (next_state != ACK);
        rd_data_nxt = '0;
        if (next_state == ACK && rw_nxt == READ) begin
            rd_data_nxt = regs[idx_nxt];
        end
    end

    // Register bank; a write commits on the edge that ends ACK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[idx_q] <= wdata_q;
        end
    end

    // Registered bus return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_    <= 1'b1;
            rd_data <= '0;
        end else begin
            rdy_    <= rdy_nxt;
            rd_data <= rd_data_nxt;
        end
    end

endmodule
